i2c_target_regs: RTL and testbench

I2C target (responder) with an internal byte-wide register file. It answers the I2C controller inside the command block at 7-bit address DEVICE_ADDR. Supports pointer-then-data writes, repeated-START pointer reads, and auto-increment. Used as the sensor-side bus model and as a synthesizable target behind the open-drain pins. A local port lets on-chip logic update registers and raise an interrupt.

---
 rtl/i2c_target_regs.sv | 264 ++++++++++++++++++++++++++
 tb/tb_i2c_target_regs.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regs.sv
// I2C target with a byte-wide register file, pointer-then-data writes,
// repeated-START pointer reads, auto-increment and a local update port.
module i2c_target_regs #(
  parameter logic [6:0]  DEVICE_ADDR = 7'h34,
  parameter int unsigned REG_AW      = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_oe,
  input  logic              loc_we,
  input  logic [REG_AW-1:0] loc_addr,
  input  logic [7:0]        loc_wdata,
  output logic [7:0]        loc_rdata,
  output logic              bus_wr_valid,
  output logic [REG_AW-1:0] bus_wr_addr,
  output logic [7:0]        bus_wr_data,
  output logic              int_o
);

  localparam int unsigned NREGS = 2**REG_AW;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ADDR     = 3'd1;
  localparam logic [2:0] S_ADDR_ACK = 3'd2;
  localparam logic [2:0] S_WR_BYTE  = 3'd3;
  localparam logic [2:0] S_WR_ACK   = 3'd4;
  localparam logic [2:0] S_RD_BYTE  = 3'd5;
  localparam logic [2:0] S_RD_ACK   = 3'd6;

  logic r_scl_s1, r_scl_s2, r_scl_d;
  logic r_sda_s1, r_sda_s2, r_sda_d;

  logic [2:0]        r_state, w_state_nxt;
  logic [3:0]        r_cnt, w_cnt_nxt;
  logic [7:0]        r_shift, w_shift_nxt;
  logic              r_sda_oe, w_sda_oe_nxt;
  logic [REG_AW-1:0] r_ptr, w_ptr_nxt;
  logic              r_rw, w_rw_nxt;
  logic              r_phase, w_phase_nxt;
  logic              r_first, w_first_nxt;
  logic              w_wr_en;
  logic              w_int_clr;

  logic              r_bus_wr_valid;
  logic [REG_AW-1:0] r_bus_wr_addr;
  logic [7:0]        r_bus_wr_data;
  logic              r_int;

  logic [7:0] r_regs [NREGS];

  logic       w_scl_rise, w_scl_fall, w_start, w_stop, w_sda;
  logic [7:0] w_byte, w_rd_data;

  // Two-stage synchronizer plus one history stage for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scl_s1 <= 1'b1;
      r_scl_s2 <= 1'b1;
      r_scl_d  <= 1'b1;
      r_sda_s1 <= 1'b1;
      r_sda_s2 <= 1'b1;
      r_sda_d  <= 1'b1;
    end else begin
      r_scl_s1 <= scl_i;
      r_scl_s2 <= r_scl_s1;
      r_scl_d  <= r_scl_s2;
      r_sda_s1 <= sda_i;
      r_sda_s2 <= r_sda_s1;
      r_sda_d  <= r_sda_s2;
    end
  end

  assign w_sda      = r_sda_s2;
  assign w_scl_rise = r_scl_s2 & ~r_scl_d;
  assign w_scl_fall = ~r_scl_s2 & r_scl_d;
  assign w_start    = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
  assign w_stop     = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;
  assign w_byte     = {r_shift[6:0], w_sda};
  assign w_rd_data  = r_regs[r_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_shift  <= '0;
      r_sda_oe <= 1'b0;
      r_ptr    <= '0;
      r_rw     <= 1'b0;
      r_phase  <= 1'b0;
      r_first  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_shift  <= w_shift_nxt;
      r_sda_oe <= w_sda_oe_nxt;
      r_ptr    <= w_ptr_nxt;
      r_rw     <= w_rw_nxt;
      r_phase  <= w_phase_nxt;
      r_first  <= w_first_nxt;
    end
  end

  // Protocol next-state; r_phase marks the ACK-driving half of an ACK slot
  // and, in S_RD_ACK, that the controller acknowledged.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_shift_nxt  = r_shift;
    w_sda_oe_nxt = r_sda_oe;
    w_ptr_nxt    = r_ptr;
    w_rw_nxt     = r_rw;
    w_phase_nxt  = r_phase;
    w_first_nxt  = r_first;
    w_wr_en      = 1'b0;
    w_int_clr    = 1'b0;

    if (w_start) begin
      w_state_nxt  = S_ADDR;
      w_cnt_nxt    = '0;
      w_sda_oe_nxt = 1'b0;
    end else if (w_stop) begin
      w_state_nxt  = S_IDLE;
      w_sda_oe_nxt = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: ;
        S_ADDR: begin
          if (w_scl_rise) begin
            w_shift_nxt = w_byte;
            w_cnt_nxt   = r_cnt + 4'd1;
            if (r_cnt == 4'd7) begin
              if (w_byte[7:1] == DEVICE_ADDR) begin
                w_rw_nxt    = w_byte[0];
                w_phase_nxt = 1'b0;
                w_state_nxt = S_ADDR_ACK;
              end else begin
                w_state_nxt = S_IDLE;
              end
            end
          end
        end
        S_ADDR_ACK: begin
          if (w_scl_fall) begin
            if (!r_phase) begin
              w_sda_oe_nxt = 1'b1;
              w_phase_nxt  = 1'b1;
            end else if (r_rw) begin
              w_shift_nxt  = w_rd_data;
              w_ptr_nxt    = r_ptr + REG_AW'(1);
              w_sda_oe_nxt = ~w_rd_data[7];
              w_cnt_nxt    = 4'd1;
              w_int_clr    = 1'b1;
              w_state_nxt  = S_RD_BYTE;
            end else begin
              w_sda_oe_nxt = 1'b0;
              w_cnt_nxt    = '0;
              w_first_nxt  = 1'b1;
              w_state_nxt  = S_WR_BYTE;
            end
          end
        end
        S_WR_BYTE: begin
          if (w_scl_rise) begin
            w_shift_nxt = w_byte;
            w_cnt_nxt   = r_cnt + 4'd1;
            if (r_cnt == 4'd7) begin
              w_cnt_nxt   = '0;
              w_phase_nxt = 1'b0;
              w_state_nxt = S_WR_ACK;
              if (r_first) begin
                w_ptr_nxt   = w_byte[REG_AW-1:0];
                w_first_nxt = 1'b0;
              end else begin
                w_wr_en   = 1'b1;
                w_ptr_nxt = r_ptr + REG_AW'(1);
              end
            end
          end
        end
        S_WR_ACK: begin
          if (w_scl_fall) begin
            if (!r_phase) begin
              w_sda_oe_nxt = 1'b1;
              w_phase_nxt  = 1'b1;
            end else begin
              w_sda_oe_nxt = 1'b0;
              w_cnt_nxt    = '0;
              w_state_nxt  = S_WR_BYTE;
            end
          end
        end
        S_RD_BYTE: begin
          if (w_scl_fall) begin
            if (r_cnt == 4'd8) begin
              w_sda_oe_nxt = 1'b0;
              w_phase_nxt  = 1'b0;
              w_state_nxt  = S_RD_ACK;
            end else begin
              w_shift_nxt  = {r_shift[6:0], 1'b0};
              w_sda_oe_nxt = ~r_shift[6];
              w_cnt_nxt    = r_cnt + 4'd1;
            end
          end
        end
        S_RD_ACK: begin
          if (w_scl_rise) begin
            if (w_sda) begin
              w_state_nxt = S_IDLE;
            end else begin
              w_phase_nxt = 1'b1;
            end
          end else if (w_scl_fall && r_phase) begin
            w_shift_nxt  = w_rd_data;
            w_ptr_nxt    = r_ptr + REG_AW'(1);
            w_sda_oe_nxt = ~w_rd_data[7];
            w_cnt_nxt    = 4'd1;
            w_state_nxt  = S_RD_BYTE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Register file: local write is applied last so it wins an address clash
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      if (w_wr_en) r_regs[r_ptr] <= w_byte;
      if (loc_we)  r_regs[loc_addr] <= loc_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bus_wr_valid <= 1'b0;
      r_bus_wr_addr  <= '0;
      r_bus_wr_data  <= '0;
      r_int          <= 1'b0;
    end else begin
      r_bus_wr_valid <= w_wr_en;
      if (w_wr_en) begin
        r_bus_wr_addr <= r_ptr;
        r_bus_wr_data <= w_byte;
      end
      if (loc_we) begin
        r_int <= 1'b1;
      end else if (w_int_clr) begin
        r_int <= 1'b0;
      end
    end
  end

  assign sda_oe       = r_sda_oe;
  assign loc_rdata    = r_regs[loc_addr];
  assign bus_wr_valid = r_bus_wr_valid;
  assign bus_wr_addr  = r_bus_wr_addr;
  assign bus_wr_data  = r_bus_wr_data;
  assign int_o        = r_int;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Scoreboard bench for i2c_target_regs: an I2C controller model drives the
// pins, expected ACKs/read bytes/bus writes are queued and checked by monitors.
module tb_i2c_target_regs;

  localparam int unsigned REG_AW = 6;
  localparam time         Q      = 50ns;

  logic              clk, rst;
  logic              m_scl, m_sda, sda_line;
  logic              sda_oe;
  logic              loc_we;
  logic [REG_AW-1:0] loc_addr;
  logic [7:0]        loc_wdata, loc_rdata;
  logic              bus_wr_valid;
  logic [REG_AW-1:0] bus_wr_addr;
  logic [7:0]        bus_wr_data;
  logic              int_o;

  int errors = 0;
  int checks = 0;

  logic [8:0]          exp_rsp_q[$];
  logic [REG_AW+7:0]   exp_wr_q[$];
  logic [8:0]          obs_val;
  event                obs_ev;

  assign sda_line = m_sda & ~sda_oe;

  i2c_target_regs #(.DEVICE_ADDR(7'h34), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst(rst), .scl_i(m_scl), .sda_i(sda_line), .sda_oe(sda_oe),
    .loc_we(loc_we), .loc_addr(loc_addr), .loc_wdata(loc_wdata),
    .loc_rdata(loc_rdata), .bus_wr_valid(bus_wr_valid),
    .bus_wr_addr(bus_wr_addr), .bus_wr_data(bus_wr_data), .int_o(int_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic loc_chk(input string name, input logic [REG_AW-1:0] a, input logic [7:0] exp);
    loc_addr = a;
    #1;
    chk(name, 16'(loc_rdata), 16'(exp));
  endtask

  // Response monitor: ACK slots are tagged with bit 8 set, read bytes clear
  initial forever begin
    logic [8:0] e;
    @(obs_ev);
    checks++;
    if (exp_rsp_q.size() == 0) begin
      errors++;
      $display("FAIL rsp_unexpected: got 0x%0h expected none", obs_val);
    end else begin
      e = exp_rsp_q.pop_front();
      if (obs_val !== e) begin
        errors++;
        $display("FAIL rsp: got 0x%0h expected 0x%0h", obs_val, e);
      end
    end
  end

  // Bus-write monitor, sampled on the inactive edge
  initial forever begin
    logic [REG_AW+7:0] e;
    @(negedge clk);
    if (bus_wr_valid) begin
      checks++;
      if (exp_wr_q.size() == 0) begin
        errors++;
        $display("FAIL bus_wr_unexpected: got addr 0x%0h data 0x%0h expected none",
                 bus_wr_addr, bus_wr_data);
      end else begin
        e = exp_wr_q.pop_front();
        if ({bus_wr_addr, bus_wr_data} !== e) begin
          errors++;
          $display("FAIL bus_wr: got addr 0x%0h data 0x%0h expected addr 0x%0h data 0x%0h",
                   bus_wr_addr, bus_wr_data, e[REG_AW+7:8], e[7:0]);
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic i2c_start();
    m_sda = 1'b1; #Q;
    m_scl = 1'b1; #Q;
    m_sda = 1'b0; #Q;
    m_scl = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; #Q;
    m_scl = 1'b1; #Q;
    m_sda = 1'b1; #Q;
  endtask

  task automatic put_bit(input logic b);
    m_sda = b; #Q;
    m_scl = 1'b1; #(2*Q);
    m_scl = 1'b0; #Q;
  endtask

  task automatic get_bit(output logic b);
    m_sda = 1'b1; #Q;
    m_scl = 1'b1; #Q;
    b = sda_line; #Q;
    m_scl = 1'b0; #Q;
  endtask

  task automatic wr_byte(input logic [7:0] d, input logic exp_ack);
    logic b;
    exp_rsp_q.push_back({1'b1, 7'd0, exp_ack});
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(b);
    obs_val = {1'b1, 7'd0, ~b};
    -> obs_ev;
  endtask

  task automatic rd_byte(input logic [7:0] exp_d, input logic ack);
    logic [7:0] d;
    logic b;
    exp_rsp_q.push_back({1'b0, exp_d});
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    obs_val = {1'b0, d};
    -> obs_ev;
    put_bit(~ack);
  endtask

  task automatic exp_wr(input logic [REG_AW-1:0] a, input logic [7:0] d);
    exp_wr_q.push_back({a, d});
  endtask

  initial begin
    logic b;
    rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1;
    loc_we = 1'b0; loc_addr = '0; loc_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (4) @(negedge clk);

    chk("rst_sda_oe", 16'(sda_oe), 16'h0);
    chk("rst_bus_wr_valid", 16'(bus_wr_valid), 16'h0);
    chk("rst_bus_wr_addr", 16'(bus_wr_addr), 16'h0);
    chk("rst_bus_wr_data", 16'(bus_wr_data), 16'h0);
    chk("rst_int_o", 16'(int_o), 16'h0);
    loc_chk("rst_reg14", 6'h14, 8'h00);

    // 1: pointer then two data bytes
    i2c_start();
    wr_byte(8'h68, 1'b1);
    wr_byte(8'h14, 1'b1);
    exp_wr(6'h14, 8'hA5); wr_byte(8'hA5, 1'b1);
    exp_wr(6'h15, 8'h5A); wr_byte(8'h5A, 1'b1);
    i2c_stop();
    loc_chk("t1_reg15", 6'h15, 8'h5A);
    loc_chk("t1_reg14", 6'h14, 8'hA5);
    chk("t1_int_o", 16'(int_o), 16'h0);

    // 2: repeated-START pointer read, ACK then NACK
    i2c_start();
    wr_byte(8'h68, 1'b1);
    wr_byte(8'h14, 1'b1);
    i2c_start();
    wr_byte(8'h69, 1'b1);
    rd_byte(8'hA5, 1'b1);
    rd_byte(8'h5A, 1'b0);
    chk("t2_sda_oe_after_nack", 16'(sda_oe), 16'h0);
    i2c_stop();

    // 3: foreign address is not acknowledged, next transaction still works
    i2c_start();
    wr_byte(8'h6A, 1'b0);
    i2c_stop();
    i2c_start();
    wr_byte(8'h68, 1'b1);
    wr_byte(8'h30, 1'b1);
    exp_wr(6'h30, 8'hC3); wr_byte(8'hC3, 1'b1);
    i2c_stop();
    loc_chk("t3_reg30", 6'h30, 8'hC3);

    // 4: pointer wrap
    i2c_start();
    wr_byte(8'h68, 1'b1);
    wr_byte(8'h3F, 1'b1);
    exp_wr(6'h3F, 8'h11); wr_byte(8'h11, 1'b1);
    exp_wr(6'h00, 8'h22); wr_byte(8'h22, 1'b1);
    i2c_stop();
    loc_chk("t4_reg3f", 6'h3F, 8'h11);
    loc_chk("t4_reg00", 6'h00, 8'h22);

    // 5: local write raises int_o, matched read clears it
    @(negedge clk);
    loc_we = 1'b1; loc_addr = 6'h3B; loc_wdata = 8'h7E;
    @(negedge clk);
    loc_we = 1'b0;
    chk("t5_int_set", 16'(int_o), 16'h1);
    loc_chk("t5_reg3b", 6'h3B, 8'h7E);
    i2c_start();
    wr_byte(8'h68, 1'b1);
    wr_byte(8'h3B, 1'b1);
    chk("t5_int_hold", 16'(int_o), 16'h1);
    i2c_start();
    wr_byte(8'h69, 1'b1);
    chk("t5_int_clr", 16'(int_o), 16'h0);
    rd_byte(8'h7E, 1'b0);
    i2c_stop();

    // 6: reset while the target drives bit 4 of 0xA5 low
    i2c_start();
    wr_byte(8'h68, 1'b1);
    wr_byte(8'h14, 1'b1);
    i2c_start();
    wr_byte(8'h69, 1'b1);
    for (int i = 0; i < 3; i++) get_bit(b);
    chk("t6_driving_bit4", 16'(sda_oe), 16'h1);
    rst = 1'b1;
    #1;
    chk("t6_rst_sda_oe", 16'(sda_oe), 16'h0);
    chk("t6_rst_bus_wr_data", 16'(bus_wr_data), 16'h0);
    loc_chk("t6_rst_reg14", 6'h14, 8'h00);
    loc_chk("t6_rst_reg3f", 6'h3F, 8'h00);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (4) @(negedge clk);
    i2c_stop();
    i2c_start();
    wr_byte(8'h68, 1'b1);
    wr_byte(8'h20, 1'b1);
    exp_wr(6'h20, 8'h99); wr_byte(8'h99, 1'b1);
    i2c_stop();
    loc_chk("t6_reg20", 6'h20, 8'h99);
    loc_chk("t6_reg15", 6'h15, 8'h00);

    #(20*Q);
    chk("rsp_queue_drained", 16'(exp_rsp_q.size()), 16'h0);
    chk("wr_queue_drained", 16'(exp_wr_q.size()), 16'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
